// File: rtl/memory_game_pkg.sv
// Shared types, LFSR constants and defaults for the memory-game round sequencer.
package memory_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    INPUT,
    JUDGE,
    DONE
  } state_t;

  // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting: feedback from bits 0,2,3,5
  localparam int unsigned      LFSR_W        = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 16'h002D;
  localparam logic [LFSR_W-1:0] DEF_SEED      = 16'hACE1;

  localparam int unsigned DEF_N_BUTTONS   = 8;
  localparam int unsigned DEF_MAX_LEN     = 16;
  localparam int unsigned DEF_N_ROUNDS    = 10;
  localparam int unsigned DEF_SHOW_CYC    = 100;
  localparam int unsigned DEF_GAP_CYC     = 50;
  localparam int unsigned DEF_TIMEOUT_CYC = 5000;

  function automatic int unsigned clamp_len(input int unsigned v, input int unsigned max_len);
    if (v == 0) return 1;
    if (v > max_len) return max_len;
    return v;
  endfunction

endpackage

// File: rtl/memory_lfsr.sv
// 16-bit Fibonacci LFSR with reseed and step enables; exposes its low OUT_W bits.
module memory_lfsr
  import memory_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = DEF_SEED,
  parameter int unsigned       OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [OUT_W-1:0] sym
);

  logic [LFSR_W-1:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state_q <= SEED;
    else if (load) state_q <= SEED;
    else if (step) state_q <= {^(state_q & LFSR_TAP_MASK), state_q[LFSR_W-1:1]};
  end

  assign sym = state_q[OUT_W-1:0];

endmodule

// File: rtl/memory_round_ctrl.sv
// Round sequencer for the LED/button memory game: generate, show, collect, judge.
// Optional input-phase timeout is built when MEMORY_TIMEOUT_EN is defined.
module memory_round_ctrl
  import memory_game_pkg::*;
#(
  parameter int unsigned       N_BUTTONS   = DEF_N_BUTTONS,
  parameter int unsigned       MAX_LEN     = DEF_MAX_LEN,
  parameter int unsigned       N_ROUNDS    = DEF_N_ROUNDS,
  parameter int unsigned       SHOW_CYC    = DEF_SHOW_CYC,
  parameter int unsigned       GAP_CYC     = DEF_GAP_CYC,
  parameter logic [LFSR_W-1:0] SEED        = DEF_SEED,
  parameter int unsigned       TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int unsigned      SYM_W       = $clog2(N_BUTTONS),
  localparam int unsigned      LEN_W       = $clog2(MAX_LEN + 1),
  localparam int unsigned      CNT_W       = $clog2(N_ROUNDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     seq_len,
  input  logic [N_BUTTONS-1:0] btn,
  output logic [N_BUTTONS-1:0] led,
  output logic                 busy,
  output logic                 input_phase,
  output logic [CNT_W-1:0]     round_cnt,
  output logic [CNT_W-1:0]     score,
  output logic                 round_done,
  output logic                 round_win,
  output logic                 game_done
);

  localparam int unsigned IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned SHOW_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
`ifdef MEMORY_TIMEOUT_EN
  localparam int unsigned TMR_MAX  = (SHOW_MAX > TIMEOUT_CYC) ? SHOW_MAX : TIMEOUT_CYC;
`else
  localparam int unsigned TMR_MAX  = SHOW_MAX;
`endif
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

  if (SEED == '0 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("memory_round_ctrl: SEED and TIMEOUT_CYC must be non-zero");
  end

  state_t               state, state_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [LEN_W-1:0]     len, len_n;
  logic [TMR_W-1:0]     tmr, tmr_n;
  logic                 win, win_n;
  logic [CNT_W-1:0]     cnt_n, score_n;
  logic                 game_done_n, busy_n, input_phase_n, round_done_n, round_win_n;
  logic [N_BUTTONS-1:0] btn_q, press, want, led_n;
  logic [SYM_W-1:0]     pat [MAX_LEN];
  logic [SYM_W-1:0]     lfsr_sym, show_sym;
  logic                 pat_we, lfsr_step, last;

  memory_lfsr #(.SEED(SEED), .OUT_W(SYM_W)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (1'b0),
    .step (lfsr_step),
    .sym  (lfsr_sym)
  );

  assign press = btn & ~btn_q;
  assign want  = N_BUTTONS'(1) << pat[idx];
  assign last  = (LEN_W'(idx) == len - LEN_W'(1));

  // Forward the symbol being written so a one-symbol round lights the right LED.
  assign show_sym = (pat_we && idx == idx_n) ? lfsr_sym : pat[idx_n];

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    len_n       = len;
    tmr_n       = tmr;
    win_n       = win;
    cnt_n       = round_cnt;
    score_n     = score;
    game_done_n = game_done;
    pat_we      = 1'b0;
    lfsr_step   = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          len_n       = LEN_W'(clamp_len(32'(seq_len), MAX_LEN));
          cnt_n       = '0;
          score_n     = '0;
          game_done_n = 1'b0;
          win_n       = 1'b0;
          idx_n       = '0;
          state_n     = GEN;
        end
      end
      GEN: begin
        pat_we    = 1'b1;
        lfsr_step = 1'b1;
        if (last) begin
          idx_n   = '0;
          tmr_n   = '0;
          state_n = SHOW_ON;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      SHOW_ON: begin
        if (tmr == TMR_W'(SHOW_CYC - 1)) begin
          tmr_n   = '0;
          state_n = SHOW_OFF;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      SHOW_OFF: begin
        if (tmr == TMR_W'(GAP_CYC - 1)) begin
          tmr_n = '0;
          if (last) begin
            idx_n   = '0;
            state_n = INPUT;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = SHOW_ON;
          end
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      INPUT: begin
        if (press != '0) begin
          if (press == want) begin
            tmr_n = '0;
            if (last) begin
              win_n   = 1'b1;
              state_n = JUDGE;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end else begin
            win_n   = 1'b0;
            state_n = JUDGE;
          end
        end
`ifdef MEMORY_TIMEOUT_EN
        else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
          win_n   = 1'b0;
          state_n = JUDGE;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
`endif
      end
      JUDGE: begin
        cnt_n = (round_cnt == CNT_W'(N_ROUNDS)) ? round_cnt : round_cnt + CNT_W'(1);
        if (win && score != CNT_W'(N_ROUNDS)) score_n = score + CNT_W'(1);
        if (32'(round_cnt) + 32'd1 >= N_ROUNDS) begin
          game_done_n = 1'b1;
          state_n     = DONE;
        end else begin
          idx_n   = '0;
          state_n = GEN;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n        = !(state_n == IDLE || state_n == DONE);
    input_phase_n = (state_n == INPUT);
    round_done_n  = (state_n == JUDGE);
    round_win_n   = (state_n == JUDGE) && win_n;
    led_n         = (state_n == SHOW_ON) ? (N_BUTTONS'(1) << show_sym) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      len         <= '0;
      tmr         <= '0;
      win         <= 1'b0;
      btn_q       <= '0;
      round_cnt   <= '0;
      score       <= '0;
      game_done   <= 1'b0;
      busy        <= 1'b0;
      input_phase <= 1'b0;
      round_done  <= 1'b0;
      round_win   <= 1'b0;
      led         <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      len         <= len_n;
      tmr         <= tmr_n;
      win         <= win_n;
      btn_q       <= btn;
      round_cnt   <= cnt_n;
      score       <= score_n;
      game_done   <= game_done_n;
      busy        <= busy_n;
      input_phase <= input_phase_n;
      round_done  <= round_done_n;
      round_win   <= round_win_n;
      led         <= led_n;
    end
  end

  // Pattern store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_LEN); i++) pat[i] <= '0;
    end else if (pat_we) begin
      pat[idx] <= lfsr_sym;
    end
  end

endmodule
